udp_frame_depacketizer: RTL and testbench
=========================================

Name: udp_frame_depacketizer

Overview:
- Parametrised successor of the team's UDP BMP-receive front end. Sits between eth_rmii UDP receive outputs (udp_rxstart/udp_rxdv/udp_rxdata) and the DDR3 write port.
- Parses a 12-byte frame header and validates it against run-time/parameter limits. Packs the following pixel bytes into DATA_W-bit words, big-endian.
- Reports frame start, completion and errors with sticky status and counters.
- Generalises the fixed 480x360/16-bit design: width, height, channels and word width are configurable.

Parameters:
- DATA_W, 16, output word width in bits; legal values 8, 16, 32, 64.
- MAX_W, 2048, largest accepted image width in pixels.
- MAX_H, 2048, largest accepted image height in pixels.
- MAX_CH, 4, largest accepted channel count (bytes per pixel).
- CHECK_DIMS, 0, 1 = header width/height must equal cfg_width/cfg_height.

Ports:
- clk  in  1  receive clock (rmii_clk domain)
- rst_n  in  1  asynchronous active-low reset
- rx_start  in  1  one-cycle pulse at start of each UDP datagram payload
- rx_dv  in  1  rx_data valid strobe
- rx_data  in  8  payload byte
- rx_end  in  1  one-cycle pulse after last byte of datagram
- cfg_width  in  16  expected width (used when CHECK_DIMS=1)
- cfg_height  in  16  expected height (used when CHECK_DIMS=1)
- wr_en  out  1  output word valid
- wr_data  out  DATA_W  packed pixel word, first byte in MSBs
- frame_vs  out  1  one-cycle pulse when a valid header is accepted
- frame_done  out  1  one-cycle pulse coincident with the last word of a frame
- frame_err  out  1  one-cycle pulse on any frame abort
- img_width  out  16  latched header width
- img_height  out  16  latched header height
- img_ch  out  8  latched channel count
- busy  out  1  high in HDR or DATA state
- frame_cnt  out  16  completed-frame counter, wraps at 65535->0
- err_cnt  out  16  aborted-frame counter, saturates at 65535

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Header layout, big-endian: 'B'(0x42), 'M'(0x4D), width[15:0], height[15:0], size[31:0], channels[15:0] = 12 bytes. The header must be the first 12 bytes of a datagram.
- States:
  - IDLE: on rx_start -> HDR with hdr byte index 0.
  - HDR: capture bytes by index.
    - Byte 0 != 0x42 or byte 1 != 0x4D -> IDLE. This is silent: no frame_err.
    - rx_end before byte 11 -> IDLE, frame_err.
    - After byte 11, validate:
      - 1 <= width <= MAX_W
      - 1 <= height <= MAX_H
      - 1 <= ch <= MAX_CH
      - size == width*height*ch, computed at 32 bits with no overflow possible given the limits
      - if CHECK_DIMS=1, width/height equal cfg_*
    - Pass: latch img_*, load byte_rem = size, pulse frame_vs the cycle after byte 11, -> DATA.
    - Fail: frame_err, -> IDLE.
  - DATA: each rx_dv byte shifts into the packer and byte_rem decrements.
    - Remaining bytes of the header datagram are pixel data.
    - Frame may span any number of datagrams; rx_start/rx_end in DATA do not change state.
- Packer:
  - Shift-left-by-8 accumulator.
  - wr_en pulses one cycle after the byte that completes DATA_W/8 bytes. Latency from byte to word = 1 clk.
- End of frame:
  - When byte_rem reaches 0, any partial word is flushed zero-padded in the LSBs, e.g. DATA_W=32 with 2 leftover bytes gives 0xAABB0000.
  - wr_en and frame_done assert together, frame_cnt increments, -> IDLE.
  - Bytes after completion in the same datagram are ignored.
- Rejection and abort in DATA:
  - A datagram whose first two bytes are 0x42,0x4D is not treated as a header in DATA; it is pixel data.
  - Abort condition: while in DATA, an idle gap of 2^24 clk with no rx_dv -> frame_err, err_cnt++, -> IDLE, partial word discarded.
- Simultaneous events:
  - rx_start coinciding with rx_dv: rx_start takes effect first; the byte is byte 0.
  - frame_done and a new rx_start in the same cycle: the new datagram is parsed in IDLE->HDR.
- rx_dv outside a datagram (no preceding rx_start) is ignored in IDLE/HDR.
- Asynchronous reset mid-frame: everything clears immediately; no flush, no frame_err.

Decomposition:
- Package udp_frame_pkg:
  - header magic constants, HDR_LEN=12
  - state enum {IDLE, HDR, DATA}
  - TIMEOUT_W=24
  - err code enum {ERR_SHORT, ERR_DIM, ERR_SIZE, ERR_TIMEOUT}
- One sub-module, byte_word_packer: byte-in/word-out with count, flush, zero-pad and clear inputs; reused by the future transmit path.

Test Plan:
- DATA_W=16: header 42 4D 01E0 0168 00054600 0002, then 345600 bytes over 361 datagrams of 960 bytes. Required: frame_vs once, 172800 wr_en, frame_done on the last word, frame_cnt=1, img_width=480, img_height=360.
- DATA_W=32: header for 3x1, ch=1, size 3, payload AA BB CC. Required: single wr_en with wr_data=0xAABBCC00 and frame_done in the same cycle.
- Bad size: header width 4, height 4, ch 2, size 31. Required: frame_err pulse, err_cnt=1, no wr_en, state IDLE.
- Datagram with first bytes 0x00 0x00: no frame_vs, no frame_err. A following valid header is accepted normally.
- CHECK_DIMS=1, cfg 480x360, header width 640: frame_err, img_width unchanged.
- Valid header, 100 pixel bytes, then silence for 2^24 clk: frame_err and return to IDLE. rst_n asserted mid-frame clears all outputs to 0 asynchronously.

Source files
------------

// File: rtl/udp_frame_pkg.sv
// Shared definitions for the UDP image-frame receive path: header layout,
// FSM states, error codes and a saturating counter helper.
package udp_frame_pkg;

  localparam logic [7:0]  HDR_MAGIC0 = 8'h42;  // 'B'
  localparam logic [7:0]  HDR_MAGIC1 = 8'h4D;  // 'M'
  localparam int unsigned HDR_LEN    = 12;
  localparam int unsigned HDR_IDX_W  = 4;
  localparam int unsigned TIMEOUT_W  = 24;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_t;

  typedef enum logic [1:0] {
    ERR_SHORT,
    ERR_DIM,
    ERR_SIZE,
    ERR_TIMEOUT
  } err_t;

  // Frame header as it arrives on the wire, first byte in the MSBs.
  typedef struct packed {
    logic [15:0] magic;
    logic [15:0] width;
    logic [15:0] height;
    logic [31:0] size;
    logic [15:0] ch;
  } hdr_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Byte-in / word-out packer, big-endian (first byte lands in the MSBs).
//   clear      : drop any partial word
//   in_valid   : in_byte is accepted this cycle
//   flush      : with in_valid, emit the word even if not yet full
//   pad_en     : on flush, left-align the partial word (zero LSBs)
//   word_valid : registered one-cycle strobe, word_data valid with it
module byte_word_packer #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  input  logic              flush,
  input  logic              pad_en,
  output logic              word_valid,
  output logic [DATA_W-1:0] word_data
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(BYTES) + 1;

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_shift_c;
  logic [DATA_W-1:0] acc_pad_c;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc_c;
  int unsigned       pad_shift_c;

  // Next accumulator value and its left-aligned form for a partial flush.
  always_comb begin
    acc_shift_c = DATA_W'({acc, in_byte});
    cnt_inc_c   = cnt + CNT_W'(1);
    pad_shift_c = 32'd8 * (BYTES - 32'(cnt_inc_c));
    acc_pad_c   = pad_en ? (acc_shift_c << pad_shift_c) : acc_shift_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (in_valid) begin
        if (cnt_inc_c == CNT_W'(BYTES)) begin
          word_valid <= 1'b1;
          word_data  <= acc_shift_c;
          acc        <= '0;
          cnt        <= '0;
        end else if (flush) begin
          word_valid <= 1'b1;
          word_data  <= acc_pad_c;
          acc        <= '0;
          cnt        <= '0;
        end else begin
          acc <= acc_shift_c;
          cnt <= cnt_inc_c;
        end
      end
    end
  end

endmodule

// File: rtl/udp_frame_depacketizer.sv
// UDP image-frame receiver: parses and validates the 12-byte 'BM' header,
// then packs the pixel bytes of the frame (spanning any number of
// datagrams) into DATA_W-bit big-endian words for the DDR write port.
//   rx_start/rx_dv/rx_data/rx_end : UDP payload stream from the MAC
//   cfg_width/cfg_height          : expected dimensions when CHECK_DIMS=1
//   wr_en/wr_data                 : packed pixel words
//   frame_vs/frame_done/frame_err : header accepted / frame complete / abort
//   img_width/img_height/img_ch   : dimensions of the last accepted header
//   busy, frame_cnt, err_cnt      : status
module udp_frame_depacketizer
  import udp_frame_pkg::*;
#(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned MAX_W         = 2048,
  parameter int unsigned MAX_H         = 2048,
  parameter int unsigned MAX_CH        = 4,
  parameter int unsigned CHECK_DIMS    = 0,
  parameter int unsigned TIMEOUT_CNT_W = TIMEOUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_start,
  input  logic              rx_dv,
  input  logic [7:0]        rx_data,
  input  logic              rx_end,
  input  logic [15:0]       cfg_width,
  input  logic [15:0]       cfg_height,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_vs,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       img_width,
  output logic [15:0]       img_height,
  output logic [7:0]        img_ch,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       err_cnt
);

  localparam int unsigned HDR_SR_W = (HDR_LEN - 1) * 8;

  state_t                   state;
  logic [HDR_IDX_W-1:0]     hdr_idx;
  logic [HDR_SR_W-1:0]      hdr_sr;
  logic [31:0]              byte_rem;
  logic [TIMEOUT_CNT_W-1:0] idle_cnt;

  logic                 hdr_restart_c;
  logic                 take_hdr_c;
  logic [HDR_IDX_W-1:0] idx_c;
  hdr_t                 hdr_c;
  logic                 magic_bad_c;
  logic                 hdr_last_c;
  logic [47:0]          prod_c;
  logic                 dims_ok_c;
  logic                 cfg_ok_c;
  logic                 hdr_ok_c;
  logic                 data_byte_c;
  logic                 last_byte_c;
  logic                 timeout_c;

  // Header byte steering and validation of the completed header.
  // hdr_c is only meaningful on the byte at index HDR_LEN-1.
  always_comb begin
    hdr_restart_c = rx_start && (state != DATA);
    idx_c         = hdr_restart_c ? '0 : hdr_idx;
    take_hdr_c    = rx_dv && (hdr_restart_c || (state == HDR));
    hdr_c         = hdr_t'({hdr_sr, rx_data});
    magic_bad_c   = ((idx_c == HDR_IDX_W'(0)) && (rx_data != HDR_MAGIC0)) ||
                    ((idx_c == HDR_IDX_W'(1)) && (rx_data != HDR_MAGIC1));
    hdr_last_c    = (idx_c == HDR_IDX_W'(HDR_LEN - 1));
    // 48-bit product so an oversized channel field cannot alias a valid size.
    prod_c        = 48'(hdr_c.width) * 48'(hdr_c.height) * 48'(hdr_c.ch);
    dims_ok_c     = (hdr_c.width  != '0) && (32'(hdr_c.width)  <= MAX_W) &&
                    (hdr_c.height != '0) && (32'(hdr_c.height) <= MAX_H) &&
                    (hdr_c.ch     != '0) && (32'(hdr_c.ch)     <= MAX_CH);
    cfg_ok_c      = (CHECK_DIMS == 0) ||
                    ((hdr_c.width == cfg_width) && (hdr_c.height == cfg_height));
    hdr_ok_c      = (hdr_c.magic == {HDR_MAGIC0, HDR_MAGIC1}) && dims_ok_c &&
                    (prod_c == 48'(hdr_c.size)) && cfg_ok_c;
    data_byte_c   = (state == DATA) && rx_dv;
    last_byte_c   = data_byte_c && (byte_rem == 32'd1);
    timeout_c     = (state == DATA) && !rx_dv && (&idle_cnt);
  end

  byte_word_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (timeout_c),
    .in_valid   (data_byte_c),
    .in_byte    (rx_data),
    .flush      (last_byte_c),
    .pad_en     (1'b1),
    .word_valid (wr_en),
    .word_data  (wr_data)
  );

  // Frame FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hdr_idx    <= '0;
      hdr_sr     <= '0;
      byte_rem   <= '0;
      idle_cnt   <= '0;
      frame_vs   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      img_width  <= '0;
      img_height <= '0;
      img_ch     <= '0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      frame_vs   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE, HDR: begin
          if (take_hdr_c) begin
            hdr_sr  <= {hdr_sr[HDR_SR_W-9:0], rx_data};
            hdr_idx <= idx_c + HDR_IDX_W'(1);
            if (magic_bad_c) begin
              // Not one of our frames: drop silently.
              state <= IDLE;
              busy  <= 1'b0;
            end else if (hdr_last_c) begin
              if (hdr_ok_c) begin
                state      <= DATA;
                busy       <= 1'b1;
                frame_vs   <= 1'b1;
                img_width  <= hdr_c.width;
                img_height <= hdr_c.height;
                img_ch     <= 8'(hdr_c.ch);
                byte_rem   <= hdr_c.size;
                idle_cnt   <= '0;
              end else begin
                state     <= IDLE;
                busy      <= 1'b0;
                frame_err <= 1'b1;
                err_cnt   <= sat_inc16(err_cnt);
              end
            end else begin
              state <= HDR;
              busy  <= 1'b1;
            end
          end else if (hdr_restart_c) begin
            state   <= HDR;
            busy    <= 1'b1;
            hdr_idx <= '0;
          end else if ((state == HDR) && rx_end) begin
            // Datagram ended inside the header.
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
            err_cnt   <= sat_inc16(err_cnt);
          end
        end
        DATA: begin
          if (rx_dv) begin
            idle_cnt <= '0;
            byte_rem <= byte_rem - 32'd1;
            if (last_byte_c) begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 16'd1;
            end
          end else if (timeout_c) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
            err_cnt   <= sat_inc16(err_cnt);
          end else begin
            idle_cnt <= idle_cnt + TIMEOUT_CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_frame_depacketizer.sv
// Directed bench for udp_frame_depacketizer: a 16-bit instance with free
// dimensions and a 32-bit instance with dimension checking, both with a
// shortened idle timeout. sel routes the receive strobes to one instance.
module tb_udp_frame_depacketizer;

  logic        clk;
  logic        rst_n;
  logic        rx_start, rx_dv, rx_end, sel;
  logic [7:0]  rx_data;
  logic [15:0] cfg_width, cfg_height;

  wire start16 = rx_start & ~sel;
  wire dv16    = rx_dv    & ~sel;
  wire end16   = rx_end   & ~sel;
  wire start32 = rx_start &  sel;
  wire dv32    = rx_dv    &  sel;
  wire end32   = rx_end   &  sel;

  logic        wr_en16, frame_vs16, frame_done16, frame_err16, busy16;
  logic [15:0] wr_data16, img_width16, img_height16, frame_cnt16, err_cnt16;
  logic [7:0]  img_ch16;
  logic        wr_en32, frame_vs32, frame_done32, frame_err32, busy32;
  logic [31:0] wr_data32;
  logic [15:0] img_width32, img_height32, frame_cnt32, err_cnt32;
  logic [7:0]  img_ch32;

  udp_frame_depacketizer #(
    .DATA_W(16), .MAX_W(2048), .MAX_H(2048), .MAX_CH(4), .CHECK_DIMS(0), .TIMEOUT_CNT_W(8)
  ) u16 (
    .clk(clk), .rst_n(rst_n), .rx_start(start16), .rx_dv(dv16), .rx_data(rx_data),
    .rx_end(end16), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .wr_en(wr_en16), .wr_data(wr_data16), .frame_vs(frame_vs16),
    .frame_done(frame_done16), .frame_err(frame_err16), .img_width(img_width16),
    .img_height(img_height16), .img_ch(img_ch16), .busy(busy16),
    .frame_cnt(frame_cnt16), .err_cnt(err_cnt16)
  );

  udp_frame_depacketizer #(
    .DATA_W(32), .MAX_W(2048), .MAX_H(2048), .MAX_CH(4), .CHECK_DIMS(1), .TIMEOUT_CNT_W(8)
  ) u32 (
    .clk(clk), .rst_n(rst_n), .rx_start(start32), .rx_dv(dv32), .rx_data(rx_data),
    .rx_end(end32), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .wr_en(wr_en32), .wr_data(wr_data32), .frame_vs(frame_vs32),
    .frame_done(frame_done32), .frame_err(frame_err32), .img_width(img_width32),
    .img_height(img_height32), .img_ch(img_ch32), .busy(busy32),
    .frame_cnt(frame_cnt32), .err_cnt(err_cnt32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse monitors, sampled on the falling edge.
  int wr16_n = 0, vs16_n = 0, done16_n = 0, err16_n = 0, dw16_n = 0;
  int wr32_n = 0, vs32_n = 0, done32_n = 0, err32_n = 0, dw32_n = 0;
  logic [15:0] wlog16[$];
  logic [31:0] wlog32[$];

  always @(negedge clk) begin
    if (wr_en16) begin wr16_n++; wlog16.push_back(wr_data16); end
    if (frame_vs16) vs16_n++;
    if (frame_done16) done16_n++;
    if (frame_err16) err16_n++;
    if (frame_done16 && wr_en16) dw16_n++;
    if (wr_en32) begin wr32_n++; wlog32.push_back(wr_data32); end
    if (frame_vs32) vs32_n++;
    if (frame_done32) done32_n++;
    if (frame_err32) err32_n++;
    if (frame_done32 && wr_en32) dw32_n++;
  end

  logic [7:0] tx_q[$];

  task automatic drive(input logic s, input logic d, input logic [7:0] b, input logic e);
    rx_start = s; rx_dv = d; rx_data = b; rx_end = e;
    @(posedge clk); #1;
    rx_start = 1'b0; rx_dv = 1'b0; rx_end = 1'b0;
  endtask

  task automatic push_hdr(input logic [15:0] w, input logic [15:0] h,
                          input logic [31:0] sz, input logic [15:0] ch);
    tx_q.push_back(8'h42); tx_q.push_back(8'h4D);
    tx_q.push_back(w[15:8]);   tx_q.push_back(w[7:0]);
    tx_q.push_back(h[15:8]);   tx_q.push_back(h[7:0]);
    tx_q.push_back(sz[31:24]); tx_q.push_back(sz[23:16]);
    tx_q.push_back(sz[15:8]);  tx_q.push_back(sz[7:0]);
    tx_q.push_back(ch[15:8]);  tx_q.push_back(ch[7:0]);
  endtask

  // One datagram from tx_q; each byte followed by an idle cycle.
  task automatic send_dgram(input bit coincide);
    if (!coincide) drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < tx_q.size(); i++) begin
      drive(coincide && (i == 0), 1'b1, tx_q[i], 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tx_q.delete();
  endtask

  task automatic test_reset();
    n_checks++; if ({wr_en16, frame_vs16, frame_done16, frame_err16, busy16} !== 5'b0) begin
      n_fail++; $display("FAIL reset_pulses16: got %b expected 00000",
                         {wr_en16, frame_vs16, frame_done16, frame_err16, busy16}); end
    n_checks++; if ({img_width16, img_height16, img_ch16, wr_data16} !== 56'h0) begin
      n_fail++; $display("FAIL reset_img16: got %h expected 0",
                         {img_width16, img_height16, img_ch16, wr_data16}); end
    n_checks++; if ({frame_cnt16, err_cnt16} !== 32'h0) begin
      n_fail++; $display("FAIL reset_cnt16: got %h expected 0", {frame_cnt16, err_cnt16}); end
    n_checks++; if ({wr_data32, busy32, frame_cnt32, err_cnt32} !== 65'h0) begin
      n_fail++; $display("FAIL reset_32: got %h expected 0",
                         {wr_data32, busy32, frame_cnt32, err_cnt32}); end
  endtask

  // Scaled multi-datagram frame: 4x3x2 = 24 bytes over three datagrams.
  task automatic test_frame16();
    int b_wr, b_vs, b_dn, b_dw, b_log;
    logic [15:0] e;
    b_wr = wr16_n; b_vs = vs16_n; b_dn = done16_n; b_dw = dw16_n; b_log = wlog16.size();
    sel = 1'b0;
    push_hdr(16'd4, 16'd3, 32'd24, 16'd2);
    for (int i = 0; i < 5; i++) tx_q.push_back(8'(i));
    send_dgram(1'b1);
    n_checks++; if (busy16 !== 1'b1) begin
      n_fail++; $display("FAIL frame16_busy: got %b expected 1", busy16); end
    for (int i = 5; i < 15; i++) tx_q.push_back(8'(i));
    send_dgram(1'b0);
    for (int i = 15; i < 24; i++) tx_q.push_back(8'(i));
    for (int i = 0; i < 3; i++) tx_q.push_back(8'hEE);
    send_dgram(1'b0);
    n_checks++; if (vs16_n - b_vs !== 1) begin
      n_fail++; $display("FAIL frame16_vs: got %0d expected 1", vs16_n - b_vs); end
    n_checks++; if (wr16_n - b_wr !== 12) begin
      n_fail++; $display("FAIL frame16_wr: got %0d expected 12", wr16_n - b_wr); end
    for (int i = 0; i < 12; i++) begin
      e = {8'(2 * i), 8'(2 * i + 1)};
      n_checks++; if (b_log + i >= wlog16.size() || wlog16[b_log + i] !== e) begin
        n_fail++; $display("FAIL frame16_word%0d: got %h expected %h", i,
                           (b_log + i < wlog16.size()) ? wlog16[b_log + i] : 16'hxxxx, e); end
    end
    n_checks++; if ((done16_n - b_dn !== 1) || (dw16_n - b_dw !== 1)) begin
      n_fail++; $display("FAIL frame16_done: got done=%0d with_wr=%0d expected 1/1",
                         done16_n - b_dn, dw16_n - b_dw); end
    n_checks++; if ({frame_cnt16, img_width16, img_height16, img_ch16, busy16} !==
                    {16'd1, 16'd4, 16'd3, 8'd2, 1'b0}) begin
      n_fail++; $display("FAIL frame16_status: got cnt=%0d w=%0d h=%0d ch=%0d busy=%b expected 1/4/3/2/0",
                         frame_cnt16, img_width16, img_height16, img_ch16, busy16); end
  endtask

  // Odd byte count on the 16-bit path: last word zero-padded.
  task automatic test_odd_flush16();
    int b_log, b_dw;
    b_log = wlog16.size(); b_dw = dw16_n;
    sel = 1'b0;
    push_hdr(16'd3, 16'd1, 32'd3, 16'd1);
    tx_q.push_back(8'hAA); tx_q.push_back(8'hBB); tx_q.push_back(8'hCC);
    send_dgram(1'b0);
    n_checks++; if ((wlog16.size() - b_log != 2) || wlog16[b_log] !== 16'hAABB ||
                    wlog16[b_log + 1] !== 16'hCC00) begin
      n_fail++; $display("FAIL odd16_words: got %0d words expected AABB,CC00", wlog16.size() - b_log); end
    n_checks++; if ((dw16_n - b_dw !== 1) || (frame_cnt16 !== 16'd2)) begin
      n_fail++; $display("FAIL odd16_done: got with_wr=%0d cnt=%0d expected 1/2", dw16_n - b_dw, frame_cnt16); end
  endtask

  task automatic test_pad32();
    int b_wr, b_dw, b_log;
    b_wr = wr32_n; b_dw = dw32_n; b_log = wlog32.size();
    sel = 1'b1;
    push_hdr(16'd3, 16'd1, 32'd3, 16'd1);
    tx_q.push_back(8'hAA); tx_q.push_back(8'hBB); tx_q.push_back(8'hCC);
    send_dgram(1'b0);
    n_checks++; if (wr32_n - b_wr !== 1) begin
      n_fail++; $display("FAIL pad32_wr: got %0d expected 1", wr32_n - b_wr); end
    n_checks++; if (wlog32.size() <= b_log || wlog32[b_log] !== 32'hAABBCC00) begin
      n_fail++; $display("FAIL pad32_data: got %h expected aabbcc00",
                         (wlog32.size() > b_log) ? wlog32[b_log] : 32'hxxxxxxxx); end
    n_checks++; if ((dw32_n - b_dw !== 1) || (frame_cnt32 !== 16'd1)) begin
      n_fail++; $display("FAIL pad32_done: got with_wr=%0d cnt=%0d expected 1/1", dw32_n - b_dw, frame_cnt32); end
  endtask

  task automatic test_bad_size();
    int b_wr, b_err, b_vs;
    b_wr = wr16_n; b_err = err16_n; b_vs = vs16_n;
    sel = 1'b0;
    push_hdr(16'd4, 16'd4, 32'd31, 16'd2);
    send_dgram(1'b0);
    n_checks++; if ((err16_n - b_err !== 1) || (err_cnt16 !== 16'd1)) begin
      n_fail++; $display("FAIL badsize_err: got pulses=%0d err_cnt=%0d expected 1/1", err16_n - b_err, err_cnt16); end
    n_checks++; if ((wr16_n != b_wr) || (vs16_n != b_vs) || busy16 !== 1'b0) begin
      n_fail++; $display("FAIL badsize_quiet: got wr=%0d vs=%0d busy=%b expected 0/0/0",
                         wr16_n - b_wr, vs16_n - b_vs, busy16); end
  endtask

  task automatic test_bad_magic();
    int b_err, b_vs, b_log;
    b_err = err16_n; b_vs = vs16_n;
    sel = 1'b0;
    tx_q.push_back(8'h00); tx_q.push_back(8'h00);
    for (int i = 0; i < 10; i++) tx_q.push_back(8'h42);
    send_dgram(1'b0);
    n_checks++; if ((vs16_n != b_vs) || (err16_n != b_err) || busy16 !== 1'b0) begin
      n_fail++; $display("FAIL magic_silent: got vs=%0d err=%0d busy=%b expected 0/0/0",
                         vs16_n - b_vs, err16_n - b_err, busy16); end
    b_log = wlog16.size();
    push_hdr(16'd2, 16'd1, 32'd2, 16'd1);
    tx_q.push_back(8'h12); tx_q.push_back(8'h34);
    send_dgram(1'b0);
    n_checks++; if ((vs16_n - b_vs !== 1) || (wlog16.size() - b_log != 1) ||
                    wlog16[b_log] !== 16'h1234 || frame_cnt16 !== 16'd3) begin
      n_fail++; $display("FAIL magic_next: got vs=%0d words=%0d cnt=%0d expected 1/1(1234)/3",
                         vs16_n - b_vs, wlog16.size() - b_log, frame_cnt16); end
  endtask

  task automatic test_short_hdr();
    int b_err;
    b_err = err16_n;
    sel = 1'b0;
    tx_q.push_back(8'h42); tx_q.push_back(8'h4D); tx_q.push_back(8'h00); tx_q.push_back(8'h04);
    send_dgram(1'b0);
    n_checks++; if ((err16_n - b_err !== 1) || (err_cnt16 !== 16'd2) || busy16 !== 1'b0) begin
      n_fail++; $display("FAIL short_hdr: got pulses=%0d err_cnt=%0d busy=%b expected 1/2/0",
                         err16_n - b_err, err_cnt16, busy16); end
  endtask

  // Second datagram starts (with its first byte) in the frame_done cycle.
  task automatic test_back_to_back();
    int b_vs, b_dn, b_log;
    logic [7:0] a[$];
    b_vs = vs16_n; b_dn = done16_n; b_log = wlog16.size();
    sel = 1'b0;
    push_hdr(16'd2, 16'd1, 32'd2, 16'd1);
    tx_q.push_back(8'h11); tx_q.push_back(8'h22);
    a = tx_q; tx_q.delete();
    push_hdr(16'd2, 16'd1, 32'd2, 16'd1);
    tx_q.push_back(8'h33); tx_q.push_back(8'h44);
    for (int i = 0; i < a.size(); i++) drive(i == 0, 1'b1, a[i], 1'b0);
    for (int i = 0; i < tx_q.size(); i++) drive(i == 0, 1'b1, tx_q[i], 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tx_q.delete();
    n_checks++; if ((vs16_n - b_vs !== 2) || (done16_n - b_dn !== 2)) begin
      n_fail++; $display("FAIL b2b_pulses: got vs=%0d done=%0d expected 2/2", vs16_n - b_vs, done16_n - b_dn); end
    n_checks++; if ((wlog16.size() - b_log != 2) || wlog16[b_log] !== 16'h1122 ||
                    wlog16[b_log + 1] !== 16'h3344 || frame_cnt16 !== 16'd5) begin
      n_fail++; $display("FAIL b2b_words: got words=%0d cnt=%0d expected 2(1122,3344)/5",
                         wlog16.size() - b_log, frame_cnt16); end
  endtask

  task automatic test_check_dims();
    int b_err, b_vs;
    b_err = err32_n; b_vs = vs32_n;
    sel = 1'b1; cfg_width = 16'd480; cfg_height = 16'd360;
    push_hdr(16'd640, 16'd360, 32'd230400, 16'd1);
    send_dgram(1'b0);
    n_checks++; if ((err32_n - b_err !== 1) || (vs32_n != b_vs) || err_cnt32 !== 16'd1) begin
      n_fail++; $display("FAIL dims_err: got err=%0d vs=%0d err_cnt=%0d expected 1/0/1",
                         err32_n - b_err, vs32_n - b_vs, err_cnt32); end
    n_checks++; if (img_width32 !== 16'd3) begin
      n_fail++; $display("FAIL dims_width_kept: got %0d expected 3", img_width32); end
  endtask

  task automatic test_timeout();
    int b_err, b_vs, b_wr, b_log, c;
    b_err = err32_n; b_vs = vs32_n; b_wr = wr32_n; b_log = wlog32.size();
    sel = 1'b1;
    push_hdr(16'd480, 16'd360, 32'd172800, 16'd1);
    for (int i = 0; i < 100; i++) tx_q.push_back(8'(i));
    send_dgram(1'b0);
    n_checks++; if ((vs32_n - b_vs !== 1) || (wr32_n - b_wr !== 25) || busy32 !== 1'b1) begin
      n_fail++; $display("FAIL to_accept: got vs=%0d wr=%0d busy=%b expected 1/25/1",
                         vs32_n - b_vs, wr32_n - b_wr, busy32); end
    n_checks++; if (wlog32.size() < b_log + 25 || wlog32[b_log] !== 32'h00010203 ||
                    wlog32[b_log + 24] !== 32'h60616263) begin
      n_fail++; $display("FAIL to_words: got %0d words expected 00010203..60616263", wlog32.size() - b_log); end
    c = 0;
    while (err32_n == b_err && c < 400) begin
      @(posedge clk); #1;
      c++;
    end
    n_checks++; if (c < 245 || c > 262) begin
      n_fail++; $display("FAIL to_latency: got %0d cycles expected 245..262", c); end
    n_checks++; if ((err_cnt32 !== 16'd2) || busy32 !== 1'b0 || frame_cnt32 !== 16'd1) begin
      n_fail++; $display("FAIL to_status: got err_cnt=%0d busy=%b cnt=%0d expected 2/0/1",
                         err_cnt32, busy32, frame_cnt32); end
  endtask

  task automatic test_reset_mid_frame();
    int b_wr, b_err;
    sel = 1'b0;
    push_hdr(16'd2, 16'd2, 32'd4, 16'd1);
    tx_q.push_back(8'hAA); tx_q.push_back(8'hBB); tx_q.push_back(8'hCC);
    send_dgram(1'b0);
    n_checks++; if (busy16 !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_busy: got %b expected 1", busy16); end
    b_wr = wr16_n + wr32_n; b_err = err16_n + err32_n;
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if ({busy16, img_width16, img_height16, img_ch16, frame_cnt16, err_cnt16, wr_data16} !== 89'h0) begin
      n_fail++; $display("FAIL rst_async16: got %h expected 0",
                         {busy16, img_width16, img_height16, img_ch16, frame_cnt16, err_cnt16, wr_data16}); end
    n_checks++; if ({frame_cnt32, err_cnt32, img_width32, wr_data32} !== 80'h0) begin
      n_fail++; $display("FAIL rst_async32: got %h expected 0", {frame_cnt32, err_cnt32, img_width32, wr_data32}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) drive(1'b0, 1'b0, 8'h00, 1'b0);
    n_checks++; if ((wr16_n + wr32_n != b_wr) || (err16_n + err32_n != b_err)) begin
      n_fail++; $display("FAIL rst_no_flush: got wr=%0d err=%0d expected 0/0",
                         wr16_n + wr32_n - b_wr, err16_n + err32_n - b_err); end
  endtask

  initial begin
    rst_n = 1'b0; rx_start = 1'b0; rx_dv = 1'b0; rx_end = 1'b0; rx_data = 8'h00;
    sel = 1'b0; cfg_width = 16'd3; cfg_height = 16'd1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0);
    test_reset();
    test_frame16();
    test_odd_flush16();
    test_pad32();
    test_bad_size();
    test_bad_magic();
    test_short_hdr();
    test_back_to_back();
    test_check_dims();
    test_timeout();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
